icache_tag_ctrl: RTL and testbench

//  Lookup/refill controller driving the 4-way I-cache tag RAM (itram, NOSYNTH form).

---
 rtl/icache_tag_ctrl.sv | 171 +++++++++++++++++
 tb/tb_icache_tag_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_tag_ctrl.sv
// icache_tag_ctrl: 4-way I-cache tag lookup/refill controller that owns the per-way valid bits.
// Optional macro ICACHE_PLRU_EN selects per-set tree pseudo-LRU replacement instead of a global round-robin.
`ifndef I_TAG_WIDTH
`define I_TAG_WIDTH 22
`endif
`ifndef I_INDEX_WIDTH
`define I_INDEX_WIDTH 6
`endif

module icache_tag_ctrl #(
    parameter int unsigned TW = `I_TAG_WIDTH,
    parameter int unsigned IW = `I_INDEX_WIDTH,
    parameter int unsigned OW = 4,
    localparam int unsigned AW = TW + IW + OW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic          cpu_ready,
    output logic          cpu_hit,
    output logic [1:0]    cpu_way,
    input  logic          inv,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    output logic          tr_en,
    output logic          tr_we,
    output logic [IW-1:0] tr_index,
    output logic [1:0]    tr_way,
    output logic [TW-1:0] tr_din,
    input  logic [TW-1:0] tr_dout0,
    input  logic [TW-1:0] tr_dout1,
    input  logic [TW-1:0] tr_dout2,
    input  logic [TW-1:0] tr_dout3
);
    localparam int unsigned NSETS = 1 << IW;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] REFILL = 2'd2;
    localparam logic [1:0] WRITE  = 2'd3;

    logic [1:0]     state, state_nxt;
    logic [TW+IW-1:0] areg;
    logic [TW-1:0]  a_tag;
    logic [IW-1:0]  a_idx;
    logic [3:0]     valid [NSETS];
    logic [3:0]     set_valid, hit;
    logic [1:0]     hit_way, free_way, policy_way, victim;
    logic           all_valid, accept;
    logic           unused_offset;

    // The line offset never reaches the tag path.
    assign unused_offset = ^cpu_addr[OW-1:0];

    assign a_tag     = areg[TW+IW-1:IW];
    assign a_idx     = areg[IW-1:0];
    assign set_valid = valid[a_idx];
    assign all_valid = &set_valid;
    assign hit       = set_valid & {tr_dout3 == a_tag, tr_dout2 == a_tag,
                                    tr_dout1 == a_tag, tr_dout0 == a_tag};
    assign hit_way   = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
    assign free_way  = !set_valid[0] ? 2'd0 : !set_valid[1] ? 2'd1 :
                       !set_valid[2] ? 2'd2 : 2'd3;

`ifdef ICACHE_PLRU_EN
    logic [2:0] plru [NSETS];
    logic [2:0] tree;
    logic [1:0] acc_way;

    // tree[0] selects the half to evict from; tree[1]/tree[2] select within the left/right pair.
    assign tree       = plru[a_idx];
    assign policy_way = tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]};
    assign acc_way    = (state == WRITE) ? victim : hit_way;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plru <= '{default: '0};
        end else if ((state == LOOKUP && |hit) || state == WRITE) begin
            plru[a_idx][0] <= ~acc_way[1];
            if (acc_way[1]) plru[a_idx][2] <= ~acc_way[0];
            else            plru[a_idx][1] <= ~acc_way[0];
        end
    end
`else
    logic [1:0] rr;
    logic       victim_full;

    assign policy_way = rr;

    // Round-robin advances only when the policy (not an invalid way) chose the victim.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr          <= 2'd0;
            victim_full <= 1'b0;
        end else begin
            if (state == LOOKUP && !(|hit)) victim_full <= all_valid;
            if (state == WRITE && victim_full) rr <= rr + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cpu_ready = 1'b0;
        cpu_hit   = 1'b0;
        cpu_way   = 2'd0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        tr_en     = 1'b0;
        tr_we     = 1'b0;
        tr_index  = '0;
        tr_way    = 2'd0;
        tr_din    = '0;
        case (state)
            IDLE: begin
                cpu_ready = ~inv;
                if (cpu_req && !inv) begin
                    accept    = 1'b1;
                    state_nxt = LOOKUP;
                end
            end
            LOOKUP: begin
                tr_en    = 1'b1;
                tr_index = a_idx;
                if (|hit) begin
                    cpu_hit   = 1'b1;
                    cpu_way   = hit_way;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {areg, OW'(0)};
                if (mem_ack) state_nxt = WRITE;
            end
            default: begin
                tr_en     = 1'b1;
                tr_we     = 1'b1;
                tr_index  = a_idx;
                tr_way    = victim;
                tr_din    = a_tag;
                state_nxt = LOOKUP;
            end
        endcase
    end

    // Request address, victim latch and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            areg   <= '0;
            victim <= 2'd0;
            valid  <= '{default: '0};
        end else begin
            if (accept) areg <= cpu_addr[AW-1:OW];
            if (state == LOOKUP && !(|hit)) victim <= all_valid ? policy_way : free_way;
            if (state == IDLE && inv)  valid <= '{default: '0};
            else if (state == WRITE)   valid[a_idx][victim] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// tb_icache_tag_ctrl: randomized self-checking bench for icache_tag_ctrl against a set-associative cache model.
// Build with ICACHE_PLRU_EN defined to check the pseudo-LRU variant.
module tb_icache_tag_ctrl;
    localparam int unsigned TW = 22, IW = 6, OW = 4, AW = TW + IW + OW;
    localparam int unsigned NSETS = 1 << IW;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cpu_req = 1'b0, inv = 1'b0, mem_ack = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic          cpu_ready, cpu_hit, mem_req, tr_en, tr_we;
    logic [1:0]    cpu_way, tr_way;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] tr_index;
    logic [TW-1:0] tr_din, tr_dout0, tr_dout1, tr_dout2, tr_dout3;

    int tests = 0, fails = 0;

    icache_tag_ctrl #(.TW(TW), .IW(IW), .OW(OW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_way(cpu_way), .inv(inv),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .tr_en(tr_en), .tr_we(tr_we), .tr_index(tr_index), .tr_way(tr_way), .tr_din(tr_din),
        .tr_dout0(tr_dout0), .tr_dout1(tr_dout1), .tr_dout2(tr_dout2), .tr_dout3(tr_dout3)
    );

    always #5 clk = ~clk;

    // Tag RAM stand-in: synchronous write, combinational read.
    logic [TW-1:0] tram [NSETS][4];
    always @(posedge clk) if (tr_en && tr_we) tram[tr_index][tr_way] <= tr_din;
    assign tr_dout0 = tram[tr_index][0];
    assign tr_dout1 = tram[tr_index][1];
    assign tr_dout2 = tram[tr_index][2];
    assign tr_dout3 = tram[tr_index][3];

    // Reference cache contents and replacement state.
    bit            m_valid [NSETS][4];
    logic [TW-1:0] m_tag   [NSETS][4];
`ifdef ICACHE_PLRU_EN
    bit m_evict_right [NSETS];
    bit m_left_lru    [NSETS];
    bit m_right_lru   [NSETS];
`else
    int m_rr;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear_valid();
        for (int s = 0; s < int'(NSETS); s++)
            for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_clear_valid();
`ifdef ICACHE_PLRU_EN
        for (int s = 0; s < int'(NSETS); s++) begin
            m_evict_right[s] = 1'b0;
            m_left_lru[s]    = 1'b0;
            m_right_lru[s]   = 1'b0;
        end
`else
        m_rr = 0;
`endif
    endtask

    function automatic int m_lookup(input logic [AW-1:0] a);
        int s = int'(a[IW+OW-1:OW]);
        for (int w = 0; w < 4; w++)
            if (m_valid[s][w] && m_tag[s][w] == a[AW-1:IW+OW]) return w;
        return -1;
    endfunction

    function automatic bit m_full(input int s);
        return m_valid[s][0] && m_valid[s][1] && m_valid[s][2] && m_valid[s][3];
    endfunction

    function automatic int m_victim(input int s);
        for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
`ifdef ICACHE_PLRU_EN
        return m_evict_right[s] ? 2 + int'(m_right_lru[s]) : int'(m_left_lru[s]);
`else
        return m_rr;
`endif
    endfunction

    // Mark a way most recently used: the eviction pointers move to the other half and the sibling.
    task automatic m_touch(input int s, input int w);
`ifdef ICACHE_PLRU_EN
        m_evict_right[s] = (w < 2);
        if (w < 2) m_left_lru[s]  = (w == 0);
        else       m_right_lru[s] = (w == 2);
`endif
    endtask

    // One complete fetch from IDLE back to IDLE; stray drives mem_ack during the lookup cycle.
    task automatic access(input logic [AW-1:0] a, input int ack_dly, input bit stray);
        int s, exp, v;
        bit full;
        logic [TW-1:0] tag;
        s   = int'(a[IW+OW-1:OW]);
        tag = a[AW-1:IW+OW];
        exp = m_lookup(a);
        cpu_addr = a; cpu_req = 1'b1; #1;
        tests++;
        if (cpu_ready !== 1'b1) begin fails++; $display("FAIL ready_idle: got %b want 1", cpu_ready); end
        tick(); cpu_req = 1'b0; mem_ack = stray; #1;
        tests++;
        if ({tr_en, tr_we, tr_index} !== {1'b1, 1'b0, IW'(s)}) begin
            fails++; $display("FAIL lookup_ram: got %h want %h", {tr_en, tr_we, tr_index}, {1'b1, 1'b0, IW'(s)});
        end
        if (exp >= 0) begin
            tests++;
            if ({cpu_hit, cpu_way, mem_req} !== {1'b1, 2'(exp), 1'b0}) begin
                fails++; $display("FAIL hit addr=%h: got hit/way/mreq %b/%0d/%b want 1/%0d/0", a, cpu_hit, cpu_way, mem_req, exp);
            end
            m_touch(s, exp);
            tick(); mem_ack = 1'b0;
            return;
        end
        tests++;
        if (cpu_hit !== 1'b0) begin fails++; $display("FAIL miss addr=%h: got hit %b want 0", a, cpu_hit); end
        v = m_victim(s);
        full = m_full(s);
        tick(); mem_ack = 1'b0; #1;
        tests++;
        if ({mem_req, mem_addr} !== {1'b1, a[AW-1:OW], 4'h0}) begin
            fails++; $display("FAIL refill_req: got %b/%h want 1/%h", mem_req, mem_addr, {a[AW-1:OW], 4'h0});
        end
        repeat (ack_dly) begin
            tick();
            tests++;
            if ({mem_req, tr_en} !== 2'b10) begin fails++; $display("FAIL refill_hold: got req/en %b want 10", {mem_req, tr_en}); end
        end
        mem_ack = 1'b1; tick(); mem_ack = 1'b0; #1;
        tests++;
        if ({tr_en, tr_we, tr_way, tr_din, tr_index} !== {2'b11, 2'(v), tag, IW'(s)}) begin
            fails++; $display("FAIL write addr=%h: got en/we/way/din/idx %b%b/%0d/%h/%h want 11/%0d/%h/%h",
                              a, tr_en, tr_we, tr_way, tr_din, tr_index, v, tag, IW'(s));
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = tag;
`ifndef ICACHE_PLRU_EN
        if (full) m_rr = (m_rr + 1) % 4;
`endif
        m_touch(s, v);
        tick();
        tests++;
        if ({cpu_hit, cpu_way, tr_we, mem_req} !== {1'b1, 2'(v), 2'b00}) begin
            fails++; $display("FAIL rehit addr=%h: got hit/way/we/mreq %b/%0d/%b/%b want 1/%0d/0/0", a, cpu_hit, cpu_way, tr_we, mem_req, v);
        end
        m_touch(s, v);
        tick();
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        tests++;
        if ({cpu_ready, cpu_hit, cpu_way, mem_req, mem_addr, tr_en, tr_we, tr_index, tr_way, tr_din} !==
            {1'b1, {(4 + AW + 2 + IW + 2 + TW){1'b0}}}) begin
            fails++; $display("FAIL reset_outputs: got ready=%b hit=%b mreq=%b maddr=%h en=%b we=%b want ready=1 rest 0",
                              cpu_ready, cpu_hit, mem_req, mem_addr, tr_en, tr_we);
        end
        tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_reset_midflow();
        cpu_addr = 32'h0000_1230; cpu_req = 1'b1;
        tick(); cpu_req = 1'b0;
        tick();
        tests++;
        if (mem_req !== 1'b1) begin fails++; $display("FAIL midflow_refill: got mreq %b want 1", mem_req); end
        rst_n = 1'b0; #1;
        tests++;
        if ({mem_req, cpu_ready, tr_en} !== 3'b010) begin
            fails++; $display("FAIL midflow_reset: got mreq/ready/en %b want 010", {mem_req, cpu_ready, tr_en});
        end
        model_reset();
        tick(); rst_n = 1'b1; tick();
    endtask

    task automatic test_cold_miss();
        access(32'h0000_1230, 2, 1'b0);
    endtask

    task automatic test_hit_latency();
        access(32'h0000_1234, 0, 1'b0);
    endtask

    task automatic test_fill_set();
        access(32'h0000_0040, 0, 1'b0);
        access(32'h0000_0440, 1, 1'b0);
        access(32'h0000_0840, 0, 1'b0);
        access(32'h0000_0C40, 3, 1'b0);
`ifdef ICACHE_PLRU_EN
        access(32'h0000_0040, 0, 1'b0);
`endif
        access(32'h0000_1040, 0, 1'b0);
    endtask

    task automatic test_inv();
        cpu_addr = 32'h0000_1230; cpu_req = 1'b1; inv = 1'b1; #1;
        tests++;
        if (cpu_ready !== 1'b0) begin fails++; $display("FAIL inv_ready: got %b want 0", cpu_ready); end
        tick(); inv = 1'b0; cpu_req = 1'b0; #1;
        tests++;
        if ({tr_en, cpu_hit, mem_req, cpu_ready} !== 4'b0001) begin
            fails++; $display("FAIL inv_not_taken: got en/hit/mreq/ready %b want 0001", {tr_en, cpu_hit, mem_req, cpu_ready});
        end
        model_clear_valid();
        access(32'h0000_1230, 1, 1'b0);
    endtask

    task automatic test_stray_ack();
        mem_ack = 1'b1;
        tick(); mem_ack = 1'b0; #1;
        tests++;
        if ({tr_en, tr_we, mem_req, cpu_ready} !== 4'b0001) begin
            fails++; $display("FAIL stray_idle: got en/we/mreq/ready %b want 0001", {tr_en, tr_we, mem_req, cpu_ready});
        end
        access(32'h0000_1230, 0, 1'b1);
        tests++;
        if ({tr_en, tr_we, mem_req, cpu_ready} !== 4'b0001) begin
            fails++; $display("FAIL stray_lookup: got en/we/mreq/ready %b want 0001", {tr_en, tr_we, mem_req, cpu_ready});
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                cpu_req = $urandom_range(0, 1) == 1; inv = 1'b1; #1;
                tests++;
                if (cpu_ready !== 1'b0) begin fails++; $display("FAIL rand_inv_ready: got %b want 0", cpu_ready); end
                tick(); inv = 1'b0; cpu_req = 1'b0;
                model_clear_valid();
            end
            a = {TW'($urandom_range(0, 5)), IW'($urandom_range(0, 3)), OW'($urandom)};
            access(a, int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_midflow();
        test_cold_miss();
        test_hit_latency();
        test_fill_set();
        test_inv();
        test_stray_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
